pid_wb_sequencer: RTL

Wishbone master that configures and drives the `pid_simple` controller core. On a start pulse it writes the four gain/setpoint registers over the core's Wishbone slave port. It then accepts feedback samples one at a time: each sample is written to the feedback register, the block waits for the core's `o_valid`, and it returns the control output `o_un` to the requester. It sits between the sample source or control logic and `pid_simple`, and is the core's only bus master.

---
 rtl/pid_seq_pkg.sv | 31 +++
 rtl/pid_wb_sequencer_if.sv | 15 +
 rtl/wb_single_writer.sv | 58 +++++
 rtl/pid_wb_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pid_seq_pkg.sv
// rtl/pid_seq_pkg.sv - shared types and register map for the pid_simple Wishbone sequencer
package pid_seq_pkg;

    localparam int DATA_W = 32;
    localparam int ADR_W  = 16;

    localparam logic [ADR_W-1:0] ADR_KP = 16'h0000;
    localparam logic [ADR_W-1:0] ADR_KI = 16'h0004;
    localparam logic [ADR_W-1:0] ADR_KD = 16'h0008;
    localparam logic [ADR_W-1:0] ADR_SP = 16'h000C;
    localparam logic [ADR_W-1:0] ADR_FB = 16'h0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_READY,
        ST_SAMP_WR,
        ST_WAIT_VALID,
        ST_ERR
    } state_t;

    function automatic logic [ADR_W-1:0] cfg_adr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADR_KP;
            2'd1:    return ADR_KI;
            2'd2:    return ADR_KD;
            default: return ADR_SP;
        endcase
    endfunction

endpackage

// File: rtl/pid_wb_sequencer_if.sv
// rtl/pid_wb_sequencer_if.sv - classic Wishbone write-only bus between sequencer and pid_simple
interface pid_wb_sequencer_if;
    import pid_seq_pkg::*;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
    logic              ack;

    modport master (output cyc, stb, we, adr, data, input ack);
    modport slave  (input cyc, stb, we, adr, data, output ack);

endinterface

// File: rtl/wb_single_writer.sv
// rtl/wb_single_writer.sv - one-shot Wishbone single write with ack timeout
module wb_single_writer
    import pid_seq_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    input  logic [ADR_W-1:0]   i_adr,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_done,
    output logic               o_timeout,
    pid_wb_sequencer_if.master wb
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADR_W-1:0]  r_adr;
    logic [DATA_W-1:0] r_data;
    logic              w_hit;

    assign w_hit     = (r_cnt == CNT_W'(TIMEOUT));
    // Ack is only meaningful while our strobe is up; a stray ack is ignored.
    assign o_done    = r_active && wb.ack;
    assign o_timeout = r_active && !wb.ack && w_hit;

    assign wb.cyc  = r_active;
    assign wb.stb  = r_active;
    assign wb.we   = r_active;
    assign wb.adr  = r_adr;
    assign wb.data = r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_adr    <= '0;
            r_data   <= '0;
        end else if (!r_active) begin
            if (i_go) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_adr    <= i_adr;
                r_data   <= i_data;
            end
        end else if (wb.ack || w_hit) begin
            r_active <= 1'b0;
            r_adr    <= '0;
            r_data   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pid_wb_sequencer.sv
// rtl/pid_wb_sequencer.sv - configures pid_simple over Wishbone and runs feedback samples through it
module pid_wb_sequencer
    import pid_seq_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [DATA_W-1:0]  i_kp,
    input  logic [DATA_W-1:0]  i_ki,
    input  logic [DATA_W-1:0]  i_kd,
    input  logic [DATA_W-1:0]  i_sp,
    input  logic               i_sample_vld,
    input  logic [DATA_W-1:0]  i_sample,
    output logic               o_sample_rdy,
    pid_wb_sequencer_if.master wb,
    input  logic               i_pid_valid,
    input  logic [DATA_W-1:0]  i_pid_un,
    output logic [DATA_W-1:0]  o_u,
    output logic               o_u_vld,
    output logic               o_busy,
    output logic               o_cfg_done,
    output logic               o_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic              r_pending;
    logic [DATA_W-1:0] r_kp, r_ki, r_kd, r_sp;
    logic [CNT_W-1:0]  r_vcnt;
    logic [DATA_W-1:0] r_u;
    logic              r_u_vld, r_busy, r_cfg_done, r_err;

    logic              w_start_acc, w_sample_acc, w_go, w_done, w_to;
    logic [ADR_W-1:0]  w_adr;
    logic [DATA_W-1:0] w_data;

    assign w_start_acc  = i_start && (r_state == ST_IDLE || r_state == ST_READY || r_state == ST_ERR);
    assign w_sample_acc = (r_state == ST_READY) && !i_start && i_sample_vld;
    // r_pending fires the next CFG write in the idle cycle right after the previous ack.
    assign w_go         = w_start_acc || w_sample_acc || r_pending;

    always_comb begin
        w_adr = cfg_adr(r_idx);
        case (r_idx)
            2'd0:    w_data = r_kp;
            2'd1:    w_data = r_ki;
            2'd2:    w_data = r_kd;
            default: w_data = r_sp;
        endcase
        if (w_sample_acc) begin
            w_adr  = ADR_FB;
            w_data = i_sample;
        end
        if (w_start_acc) begin
            w_adr  = ADR_KP;
            w_data = i_kp;
        end
    end

    wb_single_writer #(.TIMEOUT(TIMEOUT)) u_writer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_go      (w_go),
        .i_adr     (w_adr),
        .i_data    (w_data),
        .o_done    (w_done),
        .o_timeout (w_to),
        .wb        (wb)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_sp       <= '0;
            r_vcnt     <= '0;
            r_u        <= '0;
            r_u_vld    <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_u_vld   <= 1'b0;
            r_pending <= 1'b0;
            case (r_state)
                ST_IDLE, ST_READY, ST_ERR: begin
                    if (w_start_acc) begin
                        r_state    <= ST_CFG;
                        r_kp       <= i_kp;
                        r_ki       <= i_ki;
                        r_kd       <= i_kd;
                        r_sp       <= i_sp;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_cfg_done <= 1'b0;
                        r_err      <= 1'b0;
                    end else if (w_sample_acc) begin
                        r_state <= ST_SAMP_WR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CFG: begin
                    if (w_to) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_done) begin
                        if (r_idx == 2'd3) begin
                            r_state    <= ST_READY;
                            r_cfg_done <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_idx     <= r_idx + 2'd1;
                            r_pending <= 1'b1;
                        end
                    end
                end
                ST_SAMP_WR: begin
                    if (w_to) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_done) begin
                        r_state <= ST_WAIT_VALID;
                        r_vcnt  <= '0;
                    end
                end
                ST_WAIT_VALID: begin
                    if (i_pid_valid) begin
                        r_u     <= i_pid_un;
                        r_u_vld <= 1'b1;
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else if (r_vcnt == CNT_W'(TIMEOUT)) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_vcnt <= r_vcnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sample_rdy = (r_state == ST_READY) && !i_start;
    assign o_u          = r_u;
    assign o_u_vld      = r_u_vld;
    assign o_busy       = r_busy;
    assign o_cfg_done   = r_cfg_done;
    assign o_err        = r_err;

endmodule
